// File: rtl/ddr_req_arbiter_pkg.sv
// Shared definitions for the DDR request arbiter: command codes,
// read-tag source IDs and the arbiter FSM state type.
package ddr_req_arbiter_pkg;

  localparam logic [3:0] CMD_RD = 4'b0011;
  localparam logic [3:0] CMD_WR = 4'b0100;

  localparam logic [1:0] SRC_VGA  = 2'b01;
  localparam logic [1:0] SRC_UART = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/ddr_req_arbiter_rd_tag_fifo.sv
// Outstanding-read tag queue: holds the source ID of every accepted read
// so returning data can be routed back in issue order.
module rd_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [1:0] i_din,
  input  logic       i_pop,
  output logic [1:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Three-way DDR command arbiter (VGA read, camera write, UART read) with
// aging-based starvation relief and in-order routing of read returns.
module ddr_req_arbiter
  import ddr_req_arbiter_pkg::*;
#(
  parameter int AGE_MAX   = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic         clk_133M,
  input  logic         rst_n_133M,
  input  logic         cam_wr_req,
  output logic         cam_wr_gnt,
  input  logic [24:0]  cam_wr_addr,
  input  logic [127:0] cam_wr_data,
  input  logic         vga_rd_req,
  output logic         vga_rd_gnt,
  input  logic [24:0]  vga_rd_addr,
  input  logic         uart_rd_req,
  output logic         uart_rd_gnt,
  input  logic [24:0]  uart_rd_addr,
  input  logic         init_done,
  input  logic         cmd_busy,
  output logic [3:0]   cmd,
  output logic         cmd_valid,
  output logic [24:0]  ddr_address,
  output logic [127:0] ddr_wr_data,
  input  logic         ddr_data_valid,
  input  logic [127:0] ddr_rd_data,
  output logic         vga_data_valid,
  output logic [127:0] vga_rd_data,
  output logic         uart_data_valid,
  output logic [127:0] uart_rd_data,
  output logic         rd_orphan
);

  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [AW-1:0] AGE_SAT = AW'(AGE_MAX);

  state_t         r_state;
  logic           r_vga_gnt, r_cam_gnt, r_uart_gnt;
  logic [3:0]     r_cmd;
  logic           r_cmd_valid;
  logic [24:0]    r_addr;
  logic [127:0]   r_wr_data;
  logic [1:0]     r_src;
  logic [AW-1:0]  r_age [3];
  logic           r_vga_dv, r_uart_dv, r_orphan;
  logic [127:0]   r_vga_data, r_uart_data;

  // Requester index: 0 = VGA read, 1 = camera write, 2 = UART read.
  logic [2:0] w_req, w_elig, w_aged, w_cand, w_win;
  logic       w_decide, w_accept, w_push, w_pop;
  logic       w_full, w_empty;
  logic [1:0] w_tag;

  assign w_req    = {uart_rd_req, cam_wr_req, vga_rd_req};
  assign w_elig   = {uart_rd_req && !w_full, cam_wr_req, vga_rd_req && !w_full};
  assign w_decide = (r_state == ST_IDLE) && init_done && (|w_elig);
  assign w_accept = (r_state == ST_CMD) && r_cmd_valid && !cmd_busy;
  assign w_push   = w_accept && (r_cmd == CMD_RD);
  assign w_pop    = ddr_data_valid && !w_empty;

  // Aged requesters pre-empt; within either group the base order applies.
  always_comb begin
    w_aged = w_elig & {r_age[2] == AGE_SAT, r_age[1] == AGE_SAT, r_age[0] == AGE_SAT};
    w_cand = (|w_aged) ? w_aged : w_elig;
    w_win  = 3'b000;
    if (w_cand[0])      w_win = 3'b001;
    else if (w_cand[1]) w_win = 3'b010;
    else if (w_cand[2]) w_win = 3'b100;
  end

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      r_state     <= ST_IDLE;
      r_vga_gnt   <= 1'b0;
      r_cam_gnt   <= 1'b0;
      r_uart_gnt  <= 1'b0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_src       <= '0;
    end else begin
      r_vga_gnt  <= 1'b0;
      r_cam_gnt  <= 1'b0;
      r_uart_gnt <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_decide) begin
          r_state     <= ST_CMD;
          r_cmd_valid <= 1'b1;
          r_vga_gnt   <= w_win[0];
          r_cam_gnt   <= w_win[1];
          r_uart_gnt  <= w_win[2];
          if (w_win[1]) begin
            r_cmd     <= CMD_WR;
            r_addr    <= cam_wr_addr;
            r_wr_data <= cam_wr_data;
          end else begin
            r_cmd     <= CMD_RD;
            r_addr    <= w_win[0] ? vga_rd_addr : uart_rd_addr;
            r_wr_data <= '0;
            r_src     <= w_win[0] ? SRC_VGA : SRC_UART;
          end
        end
        ST_CMD: if (!cmd_busy) begin
          r_cmd_valid <= 1'b0;
          r_state     <= ST_GAP;
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      for (int i = 0; i < 3; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!w_req[i] || (w_decide && w_win[i])) r_age[i] <= '0;
        else if ((r_state == ST_IDLE) && (r_age[i] != AGE_SAT)) r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      r_vga_dv    <= 1'b0;
      r_uart_dv   <= 1'b0;
      r_vga_data  <= '0;
      r_uart_data <= '0;
      r_orphan    <= 1'b0;
    end else begin
      r_vga_dv  <= w_pop && (w_tag == SRC_VGA);
      r_uart_dv <= w_pop && (w_tag == SRC_UART);
      if (w_pop && (w_tag == SRC_VGA))  r_vga_data  <= ddr_rd_data;
      if (w_pop && (w_tag == SRC_UART)) r_uart_data <= ddr_rd_data;
      if (ddr_data_valid && w_empty) r_orphan <= 1'b1;
    end
  end

  rd_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (clk_133M),
    .rst_n   (rst_n_133M),
    .i_push  (w_push),
    .i_din   (r_src),
    .i_pop   (w_pop),
    .o_dout  (w_tag),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign vga_rd_gnt      = r_vga_gnt;
  assign cam_wr_gnt      = r_cam_gnt;
  assign uart_rd_gnt     = r_uart_gnt;
  assign cmd             = r_cmd;
  assign cmd_valid       = r_cmd_valid;
  assign ddr_address     = r_addr;
  assign ddr_wr_data     = r_wr_data;
  assign vga_data_valid  = r_vga_dv;
  assign vga_rd_data     = r_vga_data;
  assign uart_data_valid = r_uart_dv;
  assign uart_rd_data    = r_uart_data;
  assign rd_orphan       = r_orphan;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed self-checking bench for ddr_req_arbiter; inputs change and
// outputs are sampled on the falling clock edge.
module tb_ddr_req_arbiter;

  logic         clk_133M = 1'b0;
  logic         rst_n_133M;
  logic         cam_wr_req, cam_wr_gnt;
  logic [24:0]  cam_wr_addr;
  logic [127:0] cam_wr_data;
  logic         vga_rd_req, vga_rd_gnt;
  logic [24:0]  vga_rd_addr;
  logic         uart_rd_req, uart_rd_gnt;
  logic [24:0]  uart_rd_addr;
  logic         init_done, cmd_busy;
  logic [3:0]   cmd;
  logic         cmd_valid;
  logic [24:0]  ddr_address;
  logic [127:0] ddr_wr_data;
  logic         ddr_data_valid;
  logic [127:0] ddr_rd_data;
  logic         vga_data_valid, uart_data_valid, rd_orphan;
  logic [127:0] vga_rd_data, uart_rd_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_133M = ~clk_133M;

  ddr_req_arbiter #(.AGE_MAX(16), .TAG_DEPTH(8)) dut (
    .clk_133M        (clk_133M),
    .rst_n_133M      (rst_n_133M),
    .cam_wr_req      (cam_wr_req),
    .cam_wr_gnt      (cam_wr_gnt),
    .cam_wr_addr     (cam_wr_addr),
    .cam_wr_data     (cam_wr_data),
    .vga_rd_req      (vga_rd_req),
    .vga_rd_gnt      (vga_rd_gnt),
    .vga_rd_addr     (vga_rd_addr),
    .uart_rd_req     (uart_rd_req),
    .uart_rd_gnt     (uart_rd_gnt),
    .uart_rd_addr    (uart_rd_addr),
    .init_done       (init_done),
    .cmd_busy        (cmd_busy),
    .cmd             (cmd),
    .cmd_valid       (cmd_valid),
    .ddr_address     (ddr_address),
    .ddr_wr_data     (ddr_wr_data),
    .ddr_data_valid  (ddr_data_valid),
    .ddr_rd_data     (ddr_rd_data),
    .vga_data_valid  (vga_data_valid),
    .vga_rd_data     (vga_rd_data),
    .uart_data_valid (uart_data_valid),
    .uart_rd_data    (uart_rd_data),
    .rd_orphan       (rd_orphan)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_133M);
  endtask

  task automatic do_reset();
    rst_n_133M     = 1'b0;
    cam_wr_req     = 1'b0;
    vga_rd_req     = 1'b0;
    uart_rd_req    = 1'b0;
    cmd_busy       = 1'b0;
    ddr_data_valid = 1'b0;
    init_done      = 1'b1;
    step();
    step();
    rst_n_133M = 1'b1;
    step();
  endtask

  // who: 0 = VGA, 1 = camera, 2 = UART; returns at the negedge showing the grant
  task automatic wait_gnt(input int who, output logic got);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      got = (who == 0) ? vga_rd_gnt : (who == 1) ? cam_wr_gnt : uart_rd_gnt;
    end
  endtask

  initial begin
    logic         got;
    int           cnt;
    int           vcnt;
    logic         prev;
    logic [127:0] pat [3];
    logic [1:0]   who [3];

    rst_n_133M     = 1'b0;
    cam_wr_req     = 1'b0;
    vga_rd_req     = 1'b0;
    uart_rd_req    = 1'b0;
    cam_wr_addr    = '0;
    cam_wr_data    = '0;
    vga_rd_addr    = '0;
    uart_rd_addr   = '0;
    init_done      = 1'b0;
    cmd_busy       = 1'b0;
    ddr_data_valid = 1'b0;
    ddr_rd_data    = '0;
    step();
    step();
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_addr", ddr_address, 0);
    check("rst_gnts", {vga_rd_gnt, cam_wr_gnt, uart_rd_gnt}, 0);
    check("rst_orphan", rd_orphan, 0);
    rst_n_133M = 1'b1;
    step();

    // No grant while init_done is low, then immediate grant once it rises.
    vga_rd_req  = 1'b1;
    vga_rd_addr = 25'h0000ABC;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (vga_rd_gnt || cmd_valid) cnt++;
    end
    check("init_gate_no_gnt", cnt, 0);
    init_done = 1'b1;
    step();
    check("init_gnt", vga_rd_gnt, 1);
    check("init_addr", ddr_address, 25'h0000ABC);

    // Simultaneous VGA read and camera write.
    do_reset();
    vga_rd_req  = 1'b1;
    vga_rd_addr = 25'h0000100;
    cam_wr_req  = 1'b1;
    cam_wr_addr = 25'h1ABCDE0;
    cam_wr_data = 128'hA5A5_0001_0002_0003_0004_0005_0006_0007;
    step();
    check("prio_vga_gnt", vga_rd_gnt, 1);
    check("prio_cam_not_yet", cam_wr_gnt, 0);
    check("prio_rd_cmd", cmd, 4'b0011);
    check("prio_rd_valid", cmd_valid, 1);
    check("prio_rd_addr", ddr_address, 25'h0000100);
    check("prio_rd_wdata", ddr_wr_data, 0);
    vga_rd_req = 1'b0;
    step();
    check("prio_gnt_pulse", vga_rd_gnt, 0);
    step();
    check("prio_cam_gap", cam_wr_gnt, 0);
    step();
    check("prio_cam_gnt", cam_wr_gnt, 1);
    check("prio_wr_cmd", cmd, 4'b0100);
    check("prio_wr_addr", ddr_address, 25'h1ABCDE0);
    check("prio_wr_data", ddr_wr_data, 128'hA5A5_0001_0002_0003_0004_0005_0006_0007);
    cam_wr_req = 1'b0;

    // Aging: UART loses 16 IDLE decisions to VGA, then wins.
    do_reset();
    vga_rd_req   = 1'b1;
    uart_rd_req  = 1'b1;
    uart_rd_addr = 25'h0000777;
    vcnt = 0;
    got  = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      ddr_data_valid = prev;
      prev = vga_rd_gnt;
      if (vga_rd_gnt) vcnt++;
      if (uart_rd_gnt) got = 1'b1;
    end
    ddr_data_valid = 1'b0;
    check("age_uart_gnt", got, 1);
    check("age_vga_wins", vcnt, 16);
    check("age_uart_addr", ddr_address, 25'h0000777);
    vga_rd_req  = 1'b0;
    uart_rd_req = 1'b0;

    // Back-pressure: command held stable for 5 busy cycles, accepted on the 6th.
    do_reset();
    cmd_busy    = 1'b1;
    cam_wr_req  = 1'b1;
    cam_wr_addr = 25'h0123456;
    cam_wr_data = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    step();
    check("busy_gnt", cam_wr_gnt, 1);
    cam_wr_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("busy_valid_hold", cmd_valid, 1);
      check("busy_cmd_hold", cmd, 4'b0100);
      check("busy_addr_hold", ddr_address, 25'h0123456);
      check("busy_data_hold", ddr_wr_data, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    end
    cmd_busy = 1'b0;
    step();
    check("busy_accepted", cmd_valid, 0);

    // Tag queue full blocks reads but not writes; one return reopens reads.
    do_reset();
    uart_rd_req  = 1'b1;
    uart_rd_addr = 25'h0000042;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (uart_rd_gnt) cnt++;
    end
    check("full_uart_grants", cnt, 8);
    cam_wr_req = 1'b1;
    wait_gnt(1, got);
    check("full_cam_gnt", got, 1);
    cam_wr_req = 1'b0;
    step();
    step();
    ddr_rd_data    = 128'h1234;
    ddr_data_valid = 1'b1;
    step();
    ddr_data_valid = 1'b0;
    check("full_ret_dv", uart_data_valid, 1);
    check("full_ret_data", uart_rd_data, 128'h1234);
    wait_gnt(2, got);
    check("full_reopen_gnt", got, 1);
    uart_rd_req = 1'b0;

    // In-order routing of VGA, UART, VGA returns.
    do_reset();
    vga_rd_addr  = 25'h0000010;
    uart_rd_addr = 25'h0000020;
    who[0] = 2'd0;
    who[1] = 2'd2;
    who[2] = 2'd0;
    pat[0] = 128'h1111_0000_0000_0000_0000_0000_0000_00AA;
    pat[1] = 128'h2222_0000_0000_0000_0000_0000_0000_00BB;
    pat[2] = 128'h3333_0000_0000_0000_0000_0000_0000_00CC;
    for (int k = 0; k < 3; k++) begin
      if (who[k] == 2'd0) vga_rd_req = 1'b1;
      else uart_rd_req = 1'b1;
      wait_gnt(int'(who[k]), got);
      check("ord_issue_gnt", got, 1);
      vga_rd_req  = 1'b0;
      uart_rd_req = 1'b0;
    end
    step();
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      ddr_rd_data    = pat[k];
      ddr_data_valid = 1'b1;
      step();
      ddr_data_valid = 1'b0;
      check("ord_vga_dv", vga_data_valid, (who[k] == 2'd0));
      check("ord_uart_dv", uart_data_valid, (who[k] == 2'd2));
      check("ord_data", (who[k] == 2'd0) ? vga_rd_data : uart_rd_data, pat[k]);
      step();
      check("ord_dv_pulse", {vga_data_valid, uart_data_valid}, 0);
    end
    check("ord_no_orphan", rd_orphan, 0);

    // Orphan return, then asynchronous reset in the middle of a command.
    do_reset();
    ddr_rd_data    = 128'h55;
    ddr_data_valid = 1'b1;
    step();
    ddr_data_valid = 1'b0;
    check("orph_no_dv", {vga_data_valid, uart_data_valid}, 0);
    check("orph_flag", rd_orphan, 1);
    step();
    step();
    check("orph_sticky", rd_orphan, 1);
    cmd_busy    = 1'b1;
    cam_wr_req  = 1'b1;
    cam_wr_addr = 25'h1FFFFFF;
    cam_wr_data = '1;
    step();
    check("midcmd_valid", cmd_valid, 1);
    rst_n_133M = 1'b0;
    #1;
    check("arst_valid", cmd_valid, 0);
    check("arst_cmd", cmd, 0);
    check("arst_addr", ddr_address, 0);
    check("arst_wdata", ddr_wr_data, 0);
    check("arst_gnt", cam_wr_gnt, 0);
    check("arst_orphan", rd_orphan, 0);
    cam_wr_req = 1'b0;
    cmd_busy   = 1'b0;
    step();
    rst_n_133M = 1'b1;
    step();
    check("arst_stays_idle", cmd_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr_req_arbiter.md
DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

Interface
REQ-001 Parameter AGE_MAX, default 16, is the number of consecutive lost arbitration cycles after which a pending requester is promoted.
REQ-002 Parameter TAG_DEPTH, default 8, is the depth of the outstanding-read tag queue (power of 2).
REQ-003 clk_133M  in  1  sole clock; all logic is rising-edge.
REQ-004 rst_n_133M  in  1  reset, asynchronous assert, active-low.
REQ-005 cam_wr_req / cam_wr_gnt  in/out  1/1  camera write request / one-cycle grant pulse.
REQ-006 cam_wr_addr / cam_wr_data  in  25/128  camera write address / write data.
REQ-007 vga_rd_req / vga_rd_gnt  in/out  1/1  VGA read request / grant pulse.
REQ-008 vga_rd_addr  in  25  VGA read address.
REQ-009 uart_rd_req / uart_rd_gnt  in/out  1/1  UART read request / grant pulse.
REQ-010 uart_rd_addr  in  25  UART read address.
REQ-011 init_done / cmd_busy  in  1/1  DDR init complete / controller cannot accept a command.
REQ-012 cmd / cmd_valid  out  4/1  DDR command code / command-valid strobe.
REQ-013 ddr_address / ddr_wr_data  out  25/128  command address / write data.
REQ-014 ddr_data_valid / ddr_rd_data  in  1/128  read-return strobe / read data.
REQ-015 vga_data_valid / vga_rd_data  out  1/128  routed VGA read return.
REQ-016 uart_data_valid / uart_rd_data  out  1/128  routed UART read return.
REQ-017 rd_orphan  out  1  sticky error: read data returned with empty tag queue.

Function
REQ-018 FSM states IDLE, CMD, GAP; leaves IDLE only when init_done=1 and at least one eligible request exists.
REQ-019 A read request is eligible only when the tag queue is not full; a write is always eligible.
REQ-020 Base priority: vga_rd > cam_wr > uart_rd; a requester whose age counter has reached AGE_MAX takes top priority; ties among aged requesters follow base priority.
REQ-021 Per requester: the age counter increments (saturating at AGE_MAX) each IDLE cycle it is requesting and not granted, and clears on its grant or when its req is low.
REQ-022 On a decision in IDLE: grant pulse for exactly one cycle, address/data/cmd registered, cmd_valid=1 next cycle, FSM -> CMD.
REQ-023 cmd = 4'b0011 for reads, 4'b0100 for writes; ddr_wr_data = 0 for reads.
REQ-024 In CMD: cmd, ddr_address, ddr_wr_data and cmd_valid are held stable while cmd_busy=1; a command is accepted on the first cycle with cmd_valid=1 and cmd_busy=0.
REQ-025 On acceptance: cmd_valid=0 next cycle, FSM -> GAP; for a read, the 2-bit source ID (01 VGA, 10 UART) is pushed into the tag queue in the acceptance cycle.
REQ-026 GAP lasts exactly one cycle, then -> IDLE; grant-to-grant minimum spacing is 3 cycles.
REQ-027 Requesters hold req and addr/data until their gnt; a req deasserted before gnt is not serviced.
REQ-028 On ddr_data_valid=1: pop tag queue; the next cycle assert the matching *_data_valid for one cycle with the data registered (1-cycle latency).
REQ-029 ddr_data_valid with an empty tag queue: no output valid; rd_orphan set until reset.
REQ-030 Simultaneous push and pop keep the tag count unchanged; pointers wrap modulo TAG_DEPTH.
REQ-031 init_done falling mid-command does not abort CMD; no new grant is issued while init_done=0.

Reset
REQ-032 On rst_n_133M=0: FSM=IDLE, all gnt/valid strobes 0, cmd=0, ddr_address=0, ddr_wr_data=0, all read-data outputs 0, age counters 0, tag queue empty, rd_orphan=0; any in-flight command is dropped.

Structure
REQ-033 A shared package holds the command codes (CMD_RD=4'b0011, CMD_WR=4'b0100), the source-ID encodings and the FSM state type.
REQ-034 The tag queue is one sub-module, rd_tag_fifo (synchronous, TAG_DEPTH x 2 bits, with full/empty flags).

Verification
REQ-035 vga_rd_req and cam_wr_req rise together, cmd_busy=0 -> vga_rd_gnt first, cmd=0011; cam_wr_gnt 3 cycles later, cmd=0100.
REQ-036 vga_rd_req held continuously, uart_rd_req pending -> uart_rd_gnt no later than after 16 lost IDLE cycles.
REQ-037 cmd_busy=1 for 5 cycles after cmd_valid -> cmd/address/data stable for all 5 cycles; accepted on cycle 6.
REQ-038 8 UART reads issued, no returns -> 9th read request gets no grant; a camera write is still granted; one ddr_data_valid returns -> read granted again.
REQ-039 Returns for VGA,UART,VGA in issue order -> vga/uart/vga data_valid pulses, each 1 cycle after ddr_data_valid, data matching.
REQ-040 ddr_data_valid with an empty queue -> no data_valid, rd_orphan=1; reset asserted mid-CMD -> all outputs 0 immediately.
